// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Holds the redirect FSM state encodings, the default exception entry address
// and the stage index constants used to address stallreq/stall/bubble bits.
// Ports: none (package only).
package pipe_ctrl_pkg;

    // Redirect FSM encodings (plain constants so legacy tools can consume them)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Stage indices: 0 is the fetch PC stage, the last is write-back
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IC  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_DC  = 4;
    localparam int unsigned STG_MEM = 5;
    localparam int unsigned STG_WB  = 6;
    localparam int unsigned NUM_STAGES_DEFAULT = STG_WB + 1;

endpackage

// File: rtl/pipe_ctrl_stall_prio.sv
// Stall priority encoder.
// The highest stage requesting a stall holds itself and every younger stage
// in front of it, and the stage directly behind it receives a bubble.
// Ports:
//   stallreq [STAGES] in  - per-stage stall request, bit k from stage k
//   stall    [STAGES] out - bit k holds stage k's pipeline register
//   bubble   [STAGES] out - bit k loads a NOP into stage k's pipeline register
module pipe_ctrl_stall_prio #(
    parameter int unsigned STAGES = 7
) (
    input  logic [STAGES-1:0] stallreq,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble
);

    // stall[k] is the OR of all requests at index k and above
    always_comb begin
        logic any_above;
        any_above = 1'b0;
        stall     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            any_above = any_above | stallreq[k];
            stall[k]  = any_above;
        end
    end

    // The bubble goes into the first stage past the top of the stalled run
    assign bubble = {stall[STAGES-2:0] & ~stall[STAGES-1:1], 1'b0};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall / flush controller.
// Combines per-stage stall requests and the memory-side freeze into the
// stall/bubble vectors, and sequences exception/eret redirects through an
// IDLE -> (PEND) -> (FLUSH) FSM that drives flush and new_pc.
// Optional build macro: PIPE_CTRL_PERF_EN adds three saturating perf counters.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   stallreq [STAGES]           - per-stage stall requests
//   stallreq_from_outside       - memory-side stall, freezes the whole pipe
//   exc_valid, exc_is_eret      - exception / eret committing in mem stage
//   exc_epc [32]                - eret return address
//   stall, bubble [STAGES]      - per-stage hold / NOP insert
//   flush                       - kill all in-flight instructions
//   new_pc [32]                 - redirect target, zero while flush is low
//   busy                        - redirect pending or flushing
//   perf_* [32] (macro only)    - stall cycles, outside cycles, flush events
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES       = NUM_STAGES_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              stallreq_from_outside,
    input  logic              exc_valid,
    input  logic              exc_is_eret,
    input  logic [31:0]       exc_epc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_outside_cycles,
    output logic [31:0]       perf_flush_events
`endif
);

    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       tgt_q, tgt_d;
    logic [31:0]       live_tgt;
    logic              flush_raw;
    logic              in_idle;
    logic [STAGES-1:0] prio_stall, prio_bubble;

    pipe_ctrl_stall_prio #(
        .STAGES (STAGES)
    ) u_stall_prio (
        .stallreq (stallreq),
        .stall    (prio_stall),
        .bubble   (prio_bubble)
    );

    assign live_tgt = exc_is_eret ? exc_epc : EXC_VECTOR;
    assign in_idle  = (state_q == ST_IDLE);

    // cnt_q holds the number of flush cycles already spent on this redirect
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        flush_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    tgt_d = live_tgt;
                    if (!stallreq_from_outside) begin
                        flush_raw = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_d = ST_FLUSH;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!stallreq_from_outside) begin
                    flush_raw = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                flush_raw = 1'b1;
                // An outside stall keeps flush high but does not count
                if (!stallreq_from_outside) begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            tgt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    // Outputs are gated by rst so they read zero during the reset cycle itself
    always_comb begin
        flush  = flush_raw & ~rst;
        busy   = ~in_idle & ~rst;
        new_pc = 32'd0;
        if (flush) begin
            new_pc = in_idle ? live_tgt : tgt_q;
        end
        if (rst || flush) begin
            stall  = '0;
            bubble = '0;
        end else if (stallreq_from_outside) begin
            stall  = '1;
            bubble = '0;
        end else begin
            stall  = prio_stall;
            bubble = prio_bubble;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic flush_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_prev_q        <= 1'b0;
            perf_stall_cycles   <= 32'd0;
            perf_outside_cycles <= 32'd0;
            perf_flush_events   <= 32'd0;
        end else begin
            flush_prev_q <= flush;
            if (|stall && perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (stallreq_from_outside && perf_outside_cycles != 32'hFFFF_FFFF) begin
                perf_outside_cycles <= perf_outside_cycles + 32'd1;
            end
            if (flush && !flush_prev_q && perf_flush_events != 32'hFFFF_FFFF) begin
                perf_flush_events <= perf_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STAGES=7, FLUSH_CYCLES=3).
// A redirect model tracks "pending" and "flush cycles left" and is compared
// against the DUT on every negative edge; directed literal checks pin it.
module tb_pipe_ctrl;

    localparam int unsigned STG = 7;
    localparam int unsigned FC  = 3;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic           clk;
    logic           rst;
    logic [STG-1:0] stallreq;
    logic           outside;
    logic           exc_valid;
    logic           exc_is_eret;
    logic [31:0]    exc_epc;
    logic [STG-1:0] stall;
    logic [STG-1:0] bubble;
    logic           flush;
    logic [31:0]    new_pc;
    logic           busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]    perf_stall_cycles;
    logic [31:0]    perf_outside_cycles;
    logic [31:0]    perf_flush_events;
`endif

    pipe_ctrl #(
        .STAGES       (STG),
        .FLUSH_CYCLES (FC),
        .EXC_VECTOR   (VEC)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stallreq              (stallreq),
        .stallreq_from_outside (outside),
        .exc_valid             (exc_valid),
        .exc_is_eret           (exc_is_eret),
        .exc_epc               (exc_epc),
        .stall                 (stall),
        .bubble                (bubble),
        .flush                 (flush),
        .new_pc                (new_pc),
        .busy                  (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles     (perf_stall_cycles),
        .perf_outside_cycles   (perf_outside_cycles),
        .perf_flush_events     (perf_flush_events)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: a redirect waiting for the outside stall, flush cycles still owed
    bit          m_pending;
    int          m_left;
    logic [31:0] m_target;
    bit          m_prev_flush;
    int unsigned m_flush_events;

    logic [6:0]  e_stall, e_bubble;
    logic        e_flush, e_busy, m_idle;
    logic [31:0] e_pc, live;

    initial begin
        m_pending      = 1'b0;
        m_left         = 0;
        m_target       = 32'd0;
        m_prev_flush   = 1'b0;
        m_flush_events = 0;
    end

    // Highest requesting stage k -> stall = 2^(k+1)-1, bubble = 2^(k+1) (dropped past WB)
    function automatic void prio(input logic [6:0] sr, output logic [6:0] st, output logic [6:0] bu);
        int hi;
        int unsigned m;
        hi = -1;
        for (int i = 0; i < 7; i++) if (sr[i]) hi = i;
        if (hi < 0) begin
            st = 7'd0;
            bu = 7'd0;
        end else begin
            m  = (32'd1 << (hi + 1));
            st = 7'(m - 1);
            bu = 7'(m);
        end
    endfunction

    always @(negedge clk) begin
        if (!done) begin
            live = exc_is_eret ? exc_epc : VEC;
            m_idle = !m_pending && (m_left == 0);
            if (rst) begin
                e_flush = 1'b0; e_busy = 1'b0; e_pc = 32'd0;
                e_stall = 7'd0; e_bubble = 7'd0;
            end else begin
                e_flush = (m_left > 0) || (m_pending && !outside)
                          || (m_idle && exc_valid && !outside);
                e_busy  = !m_idle;
                e_pc    = e_flush ? (m_idle ? live : m_target) : 32'd0;
                if (e_flush) begin
                    e_stall = 7'd0; e_bubble = 7'd0;
                end else if (outside) begin
                    e_stall = 7'h7F; e_bubble = 7'd0;
                end else begin
                    prio(stallreq, e_stall, e_bubble);
                end
            end
            check("cmp_stall",  {25'd0, stall},  {25'd0, e_stall});
            check("cmp_bubble", {25'd0, bubble}, {25'd0, e_bubble});
            check("cmp_flush",  {31'd0, flush},  {31'd0, e_flush});
            check("cmp_busy",   {31'd0, busy},   {31'd0, e_busy});
            check("cmp_new_pc", new_pc, e_pc);
`ifdef PIPE_CTRL_PERF_EN
            check("cmp_perf_flush", perf_flush_events, m_flush_events);
`endif
            // Advance the model to what the next posedge leaves behind
            if (rst) begin
                m_pending = 1'b0; m_left = 0; m_target = 32'd0;
                m_prev_flush = 1'b0; m_flush_events = 0;
            end else begin
                if (e_flush && !m_prev_flush) m_flush_events++;
                m_prev_flush = e_flush;
                if (m_idle && exc_valid) begin
                    m_target = live;
                    if (outside) m_pending = 1'b1;
                    else         m_left = FC - 1;
                end else if (m_pending && !outside) begin
                    m_pending = 1'b0;
                    m_left    = FC - 1;
                end else if (m_left > 0 && !outside) begin
                    m_left--;
                end
            end
        end
    end

    // One cycle of stimulus; returns just after the negedge so outputs are settled
    task automatic tick(input logic r, input logic [6:0] sr, input logic o,
                        input logic e, input logic er, input logic [31:0] epc);
        @(posedge clk);
        #1;
        rst = r; stallreq = sr; outside = o;
        exc_valid = e; exc_is_eret = er; exc_epc = epc;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [6:0] st, input logic [6:0] bu,
                       input logic fl, input logic [31:0] pc);
        check({name, "_stall"},  {25'd0, stall},  {25'd0, st});
        check({name, "_bubble"}, {25'd0, bubble}, {25'd0, bu});
        check({name, "_flush"},  {31'd0, flush},  {31'd0, fl});
        check({name, "_new_pc"}, new_pc, pc);
    endtask

    initial begin
        rst = 1'b1; stallreq = '0; outside = 1'b0;
        exc_valid = 1'b0; exc_is_eret = 1'b0; exc_epc = 32'd0;
        tick(1, 7'h00, 0, 0, 0, 0);
        tick(1, 7'h08, 1, 1, 0, 0);
        lit("reset", 7'h00, 7'h00, 0, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Stall priority patterns
        tick(0, 7'b0001000, 0, 0, 0, 0);  lit("prio_ex",   7'b0001111, 7'b0010000, 0, 0);
        tick(0, 7'b0001000, 1, 0, 0, 0);  lit("outside",   7'b1111111, 7'b0000000, 0, 0);
        tick(0, 7'b1000000, 0, 0, 0, 0);  lit("prio_wb",   7'b1111111, 7'b0000000, 0, 0);
        tick(0, 7'b0000001, 0, 0, 0, 0);  lit("prio_pc",   7'b0000001, 7'b0000010, 0, 0);
        tick(0, 7'b0100100, 0, 0, 0, 0);  lit("prio_mem",  7'b0111111, 7'b1000000, 0, 0);
        tick(0, 7'b0000000, 0, 0, 0, 0);  lit("prio_none", 7'b0000000, 7'b0000000, 0, 0);

        // Exception, three flush cycles to the vector
        tick(0, 7'h00, 0, 1, 0, 32'h1111_1111); lit("exc_f1", 0, 0, 1, VEC);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("exc_f2", 0, 0, 1, VEC);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("exc_f3", 0, 0, 1, VEC);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("exc_done", 0, 0, 0, 0);
        check("exc_done_busy", {31'd0, busy}, 32'd0);

        // eret held off by outside stall for 4 cycles
        tick(0, 7'h00, 1, 1, 1, 32'h8000_1234); lit("eret_p0", 7'h7F, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 7'h00, 1, 0, 0, 0);         lit("eret_pend", 7'h7F, 0, 0, 0);
            check("eret_pend_busy", {31'd0, busy}, 32'd1);
        end
        tick(0, 7'h00, 0, 0, 0, 0);             lit("eret_go", 0, 0, 1, 32'h8000_1234);
        tick(0, 7'h00, 0, 0, 0, 0);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("eret_f3", 0, 0, 1, 32'h8000_1234);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("eret_done", 0, 0, 0, 0);

        // Flush overrides stall requests; a second exception is ignored
        tick(0, 7'b1000000, 0, 1, 0, 0);        lit("ovr_f1", 0, 0, 1, VEC);
        tick(0, 7'b1111111, 0, 1, 1, 32'h1234_5678); lit("ovr_f2", 0, 0, 1, VEC);
        tick(0, 7'b0000100, 0, 0, 0, 0);        lit("ovr_f3", 0, 0, 1, VEC);
        tick(0, 7'b0000100, 0, 0, 0, 0);        lit("ovr_done", 7'b0000111, 7'b0001000, 0, 0);

        // Outside stall during FLUSH freezes the count
        tick(0, 7'h00, 0, 1, 1, 32'h0000_0400); lit("frz_f1", 0, 0, 1, 32'h400);
        tick(0, 7'h00, 1, 0, 0, 0);             lit("frz_hold", 0, 0, 1, 32'h400);
        tick(0, 7'h00, 1, 0, 0, 0);
        tick(0, 7'h00, 0, 0, 0, 0);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("frz_last", 0, 0, 1, 32'h400);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("frz_done", 0, 0, 0, 0);

        // Reset in the second flush cycle abandons the redirect
        tick(0, 7'h00, 0, 1, 0, 0);             lit("rstf_f1", 0, 0, 1, VEC);
        tick(1, 7'h08, 0, 0, 0, 0);             lit("rstf_rst", 0, 0, 0, 0);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("rstf_after", 0, 0, 0, 0);
        check("rstf_busy", {31'd0, busy}, 32'd0);

        // Reset during PEND: no flush when outside later drops
        tick(0, 7'h00, 1, 1, 1, 32'hDEAD_BEE0);
        tick(0, 7'h00, 1, 0, 0, 0);
        tick(1, 7'h00, 1, 0, 0, 0);
        tick(0, 7'h00, 0, 0, 0, 0);             lit("rstp_after", 0, 0, 0, 0);

        // Second redirect after reset, eret target, then idle traffic
        tick(0, 7'b0010000, 0, 1, 1, 32'h0000_0ABC); lit("re_f1", 0, 0, 1, 32'hABC);
        tick(0, 7'b0010000, 0, 0, 0, 0);
        tick(0, 7'b0010000, 0, 0, 0, 0);
        tick(0, 7'b0010000, 0, 0, 0, 0);        lit("re_done", 7'b0011111, 7'b0100000, 0, 0);
        tick(0, 7'b0000010, 0, 0, 0, 0);        lit("prio_ic", 7'b0000011, 7'b0000100, 0, 0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
